mpu_store: RTL and testbench

// - Store-side datapath of the MPU, the counterpart to the MPU load path.
// - On an MPU STORE operation, reads one matrix from the matrix register file.
// - Streams it out one FP element per beat, row-major, on a valid/ready interface.
// - Sits between the MPU control decode (mpu_operation_t == STORE) and the external memory/testbench sink.
//

---
 rtl/mpu_pkg.sv | 31 +++
 rtl/mpu_store_index_counter.sv | 62 ++++++
 rtl/mpu_store.sv | 135 +++++++++++++
 tb/tb_mpu_store.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mpu_pkg.sv
// Shared MPU definitions for the store datapath.
// Holds the matrix sizing, the derived index/dimension widths, the store FSM
// state type and a helper that validates requested store dimensions.
package mpu_pkg;

   localparam int FP               = 32;
   localparam int M                = 2;
   localparam int N                = 2;
   localparam int MATRIX_REGISTERS = 16;

   localparam int RB = $clog2(MATRIX_REGISTERS);
   localparam int MB = $clog2(M + 1);
   localparam int NB = $clog2(N + 1);
   localparam int RW = (M > 1) ? $clog2(M) : 1;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   // Width of a flat row-major element index into the capture buffer.
   localparam int EW = (M * N > 1) ? $clog2(M * N) : 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_CAPTURE,
      ST_STREAM,
      ST_DONE
   } store_fsm_t;

   function automatic logic dims_legal(input logic [MB-1:0] m, input logic [NB-1:0] n);
      return (m != '0) && (n != '0) && (m <= MB'(M)) && (n <= NB'(N));
   endfunction

endpackage

// File: rtl/mpu_store_index_counter.sv
// Row/column beat counter for the store stream.
// Ports:
//   clk, rst    clock and synchronous active-low reset
//   clr         force row and col back to 0
//   adv         step to the next element in row-major order
//   m, n        active matrix dimensions (1..M, 1..N)
//   row, col    current element indices
//   last        current element is (m-1, n-1)
module store_index_counter
   import mpu_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          adv,
   input  logic [MB-1:0] m,
   input  logic [NB-1:0] n,
   output logic [RW-1:0] row,
   output logic [CW-1:0] col,
   output logic          last
);

   logic [RW-1:0] row_q, row_d;
   logic [CW-1:0] col_q, col_d;
   logic          col_end;
   logic          row_end;

   // Wrap against the active width n, not the storage stride N.
   assign col_end = (NB'(col_q) == (n - NB'(1)));
   assign row_end = (MB'(row_q) == (m - MB'(1)));

   always_comb begin
      row_d = row_q;
      col_d = col_q;
      if (clr) begin
         row_d = '0;
         col_d = '0;
      end else if (adv) begin
         if (col_end) begin
            col_d = '0;
            row_d = row_q + RW'(1);
         end else begin
            col_d = col_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         row_q <= '0;
         col_q <= '0;
      end else begin
         row_q <= row_d;
         col_q <= col_d;
      end
   end

   assign row  = row_q;
   assign col  = col_q;
   assign last = row_end && col_end;

endmodule

// File: rtl/mpu_store.sv
// MPU store datapath: fetches one matrix from the register file, captures it
// locally and streams it out one element per beat, row-major.
// Ports:
//   clk, rst                         clock, synchronous active-low reset
//   store_req/reg/m/n                store request and its operands
//   store_ready/done/error           handshake and status pulses
//   rf_rd_en/addr, rf_rd_data        register file read port (1-cycle latency)
//   out_valid/ready                  element stream handshake
//   out_element/row/col/last         element beat payload
module mpu_store
   import mpu_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              store_req,
   input  logic [RB-1:0]     store_reg,
   input  logic [MB-1:0]     store_m,
   input  logic [NB-1:0]     store_n,
   output logic              store_ready,
   output logic              store_done,
   output logic              store_error,
   output logic              rf_rd_en,
   output logic [RB-1:0]     rf_rd_addr,
   input  logic [M*N*FP-1:0] rf_rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [FP-1:0]     out_element,
   output logic [RW-1:0]     out_row,
   output logic [CW-1:0]     out_col,
   output logic              out_last
);

   store_fsm_t         state_q, state_d;
   logic [RB-1:0]      reg_q, reg_d;
   logic [MB-1:0]      m_q, m_d;
   logic [NB-1:0]      n_q, n_d;
   logic [M*N*FP-1:0]  mat_q, mat_d;
   logic               error_q, error_d;
   logic               cnt_clr, cnt_adv, cnt_last;
   logic [RW-1:0]      cnt_row;
   logic [CW-1:0]      cnt_col;
   logic [EW-1:0]      elem_idx;
   logic [FP-1:0]      elem [M*N];
   logic               streaming;

   for (genvar gi = 0; gi < M * N; gi++) begin : g_elem
      assign elem[gi] = mat_q[gi*FP +: FP];
   end

   store_index_counter u_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (cnt_clr),
      .adv  (cnt_adv),
      .m    (m_q),
      .n    (n_q),
      .row  (cnt_row),
      .col  (cnt_col),
      .last (cnt_last)
   );

   always_comb begin
      state_d = state_q;
      reg_d   = reg_q;
      m_d     = m_q;
      n_d     = n_q;
      mat_d   = mat_q;
      error_d = 1'b0;
      cnt_clr = 1'b0;
      cnt_adv = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (store_req) begin
               if (dims_legal(store_m, store_n)) begin
                  reg_d   = store_reg;
                  m_d     = store_m;
                  n_d     = store_n;
                  state_d = ST_FETCH;
               end else begin
                  error_d = 1'b1;
               end
            end
         end
         ST_FETCH: state_d = ST_CAPTURE;
         ST_CAPTURE: begin
            // Only sampling point of rf_rd_data; later RF writes cannot leak in.
            mat_d   = rf_rd_data;
            cnt_clr = 1'b1;
            state_d = ST_STREAM;
         end
         ST_STREAM: begin
            if (out_ready) begin
               if (cnt_last) state_d = ST_DONE;
               else          cnt_adv = 1'b1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         reg_q   <= '0;
         m_q     <= '0;
         n_q     <= '0;
         mat_q   <= '0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         reg_q   <= reg_d;
         m_q     <= m_d;
         n_q     <= n_d;
         mat_q   <= mat_d;
         error_q <= error_d;
      end
   end

   // Stride is the storage width N, independent of the active n.
   assign elem_idx  = EW'(cnt_row) * EW'(N) + EW'(cnt_col);
   assign streaming = (state_q == ST_STREAM);

   assign store_ready = (state_q == ST_IDLE);
   assign store_done  = (state_q == ST_DONE);
   assign store_error = error_q;
   assign rf_rd_en    = (state_q == ST_FETCH);
   assign rf_rd_addr  = (state_q == ST_FETCH) ? reg_q : '0;
   assign out_valid   = streaming;
   assign out_element = streaming ? elem[elem_idx] : '0;
   assign out_row     = streaming ? cnt_row : '0;
   assign out_col     = streaming ? cnt_col : '0;
   assign out_last    = streaming && cnt_last;

endmodule

// File: tb/tb_mpu_store.sv
module tb_mpu_store;
   import mpu_pkg::*;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              store_req = 1'b0;
   logic [RB-1:0]     store_reg = '0;
   logic [MB-1:0]     store_m = '0;
   logic [NB-1:0]     store_n = '0;
   logic              store_ready, store_done, store_error;
   logic              rf_rd_en;
   logic [RB-1:0]     rf_rd_addr;
   logic [M*N*FP-1:0] rf_rd_data;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [FP-1:0]     out_element;
   logic [RW-1:0]     out_row;
   logic [CW-1:0]     out_col;
   logic              out_last;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   logic [M*N*FP-1:0] rf_mem [MATRIX_REGISTERS];
   logic [RB-1:0]     rf_addr_q = '0;
   logic [34:0]       exp_q [$];

   mpu_store dut (
      .clk         (clk),
      .rst         (rst),
      .store_req   (store_req),
      .store_reg   (store_reg),
      .store_m     (store_m),
      .store_n     (store_n),
      .store_ready (store_ready),
      .store_done  (store_done),
      .store_error (store_error),
      .rf_rd_en    (rf_rd_en),
      .rf_rd_addr  (rf_rd_addr),
      .rf_rd_data  (rf_rd_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_element (out_element),
      .out_row     (out_row),
      .out_col     (out_col),
      .out_last    (out_last)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Register file model: address registered on rd_en, data read live from
   // the array so later writes would be visible to a late sampler.
   always @(posedge clk) if (rf_rd_en) rf_addr_q <= rf_rd_addr;
   assign rf_rd_data = rf_mem[rf_addr_q];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Issue a request in the next idle-side cycle; returns cycle T of the request.
   task automatic issue(input int r, input int m, input int n, output int t);
      logic [M*N*FP-1:0] mat;
      bit legal;
      @(negedge clk);
      t = cyc;
      check("req_ready", store_ready, 1);
      store_req = 1'b1;
      store_reg = RB'(r);
      store_m   = MB'(m);
      store_n   = NB'(n);
      legal = (m >= 1) && (m <= M) && (n >= 1) && (n <= N);
      mat = rf_mem[r];
      if (legal)
         for (int i = 0; i < m; i++)
            for (int j = 0; j < n; j++)
               exp_q.push_back({1'(i), 1'(j), (i == m - 1) && (j == n - 1),
                                mat[(i*N+j)*FP +: FP]});
      @(negedge clk);
      store_req = 1'b0;
      if (legal) begin
         check("rd_en_t1", rf_rd_en, 1);
         check("rd_addr_t1", rf_rd_addr, 64'(r));
      end else begin
         check("err_pulse", store_error, 1);
         check("err_no_rd", rf_rd_en, 0);
         check("err_ready", store_ready, 1);
      end
      $display("request reg=%0d m=%0d n=%0d legal=%0d at cycle %0d", r, m, n, legal, t);
   endtask

   // Consume a stream. stall_beat/stall_len: hold out_ready low; rst_beat:
   // pull reset when that beat is presented; ign_beat: stray request.
   task automatic run_stream(input int t, input int nbeats, input int stall_beat,
                             input int stall_len, input int rst_beat, input int ign_beat,
                             input bit chk_lat, input bit clobber);
      int beats = 0;
      int stall_left = stall_len;
      int first = -1;
      bit done_seen = 0;
      logic [34:0] held = '0;
      logic [34:0] obs;
      logic [34:0] e;
      for (int k = 0; k < 60 && !done_seen; k++) begin
         @(negedge clk);
         store_req = 1'b0;
         if (store_done) begin
            done_seen = 1;
            check("done_beats", 64'(beats), 64'(nbeats));
            check("done_q_empty", 64'(exp_q.size()), 0);
            if (chk_lat) check("done_lat", 64'(cyc - t), 64'(3 + nbeats));
            $display("done at cycle %0d after %0d beats", cyc, beats);
         end else if (out_valid) begin
            obs = {out_row, out_col, out_last, out_element};
            if (first < 0) begin
               first = cyc;
               if (chk_lat) check("first_lat", 64'(cyc - t), 3);
            end
            if (beats == rst_beat) begin
               rst = 1'b0;
               out_ready = 1'b1;
               @(negedge clk);
               rst = 1'b1;
               check("rst_valid", out_valid, 0);
               check("rst_ready", store_ready, 1);
               check("rst_no_done", store_done, 0);
               exp_q.delete();
               $display("reset during beat %0d at cycle %0d", beats, cyc);
               return;
            end
            if (beats == ign_beat) begin
               store_req = 1'b1;
               store_reg = RB'(5);
               store_m   = MB'(2);
               store_n   = NB'(2);
            end
            if (beats == stall_beat && stall_left > 0) begin
               out_ready = 1'b0;
               if (stall_left < stall_len) check("stall_hold", obs, held);
               held = obs;
               stall_left--;
            end else begin
               out_ready = 1'b1;
               if (exp_q.size() == 0) begin
                  check("extra_beat", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  check("beat", obs, e);
               end
               $display("beat %0d row=%0d col=%0d last=%0d elem=0x%08h", beats,
                        out_row, out_col, out_last, out_element);
               beats++;
               if (clobber) rf_mem[3] = '0;
            end
         end
      end
      if (!done_seen) check("done_timeout", 0, 1);
      out_ready = 1'b1;
   endtask

   initial begin
      int t;
      for (int i = 0; i < MATRIX_REGISTERS; i++)
         rf_mem[i] = {32'(i*16+4), 32'(i*16+3), 32'(i*16+2), 32'(i*16+1)};
      rf_mem[3] = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};

      repeat (3) @(negedge clk);
      check("rst_ready", store_ready, 1);
      check("rst_valid", out_valid, 0);
      check("rst_rd_en", rf_rd_en, 0);
      check("rst_done", store_done, 0);
      check("rst_error", store_error, 0);
      rst = 1'b1;

      // Basic 2x2 with latency checks; RF overwritten mid-stream.
      issue(3, 2, 2, t);
      run_stream(t, 4, -1, 0, -1, -1, 1, 1);
      rf_mem[3] = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};

      // 1x2 from a 2x2 register.
      issue(3, 1, 2, t);
      run_stream(t, 2, -1, 0, -1, -1, 1, 0);

      // Backpressure at beat (0,1) for 3 cycles.
      issue(7, 2, 2, t);
      run_stream(t, 4, 1, 3, -1, -1, 0, 0);

      // Illegal dimensions.
      issue(3, 0, 2, t);
      @(negedge clk);
      check("err_clear", store_error, 0);
      check("err_no_rd2", rf_rd_en, 0);
      issue(3, 2, 3, t);
      @(negedge clk);
      check("err_clear2", store_error, 0);
      check("err_ready2", store_ready, 1);

      // Reset during beat (1,0), then a fresh stream.
      issue(3, 2, 2, t);
      run_stream(t, 4, -1, 0, 2, -1, 0, 0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("post_rst_done", store_done, 0);
      end
      issue(9, 2, 2, t);
      run_stream(t, 4, -1, 0, -1, -1, 1, 0);

      // Stray request during streaming is dropped.
      issue(3, 2, 1, t);
      run_stream(t, 2, -1, 0, -1, 1, 1, 0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("ignored_req", rf_rd_en, 0);
      end

      // Back-to-back request right after done.
      issue(2, 2, 2, t);
      run_stream(t, 4, -1, 0, -1, -1, 1, 0);
      issue(4, 1, 1, t);
      run_stream(t, 1, -1, 0, -1, -1, 1, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
